// File: rtl/burst_framer.sv
// Burst framer: groups a valid/ready word stream into bursts, flagging the final
// word of each burst with o_last (full length, idle timeout or flush request).
module burst_framer #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [15:0]       o_burst_count
);

  localparam logic [15:0] LEN      = 16'(BURST_LEN);
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] IDLE_MAX = TMO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
    return (v >= lim) ? lim : v + 16'd1;
  endfunction

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [15:0]       pos_p0;
  logic [15:0]       nxt_pos;
  logic [15:0]       idle_p0;

  logic        out_free;
  logic        accept;
  logic        full;
  logic        tmo_hit;
  logic        flush_hit;
  logic        push;
  logic        push_last;
  logic [15:0] pos_next;

  always_comb begin
    out_free  = !o_valid || i_ready;
    o_ready   = !rst && (!vld_p0 || out_free);
    accept    = i_valid && o_ready;
    full      = (pos_p0 == LEN);
    tmo_hit   = TMO_EN && (idle_p0 == IDLE_MAX) && !i_valid;
    flush_hit = i_flush && !i_valid;
    push      = vld_p0 && out_free && (full || accept || tmo_hit || flush_hit);
    // A full burst always closes; otherwise arriving data overrides timeout/flush
    push_last = full || !accept;
    pos_next  = push ? (push_last ? 16'd1 : pos_p0 + 16'd1) : nxt_pos;
  end

  // Stage p0: holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      pos_p0  <= 16'd1;
      nxt_pos <= 16'd1;
      idle_p0 <= 16'd0;
    end else begin
      if (accept) begin
        vld_p0 <= 1'b1;
        pos_p0 <= pos_next;
      end else if (push) begin
        vld_p0 <= 1'b0;
      end
      if (push) begin
        nxt_pos <= pos_next;
      end
      if (accept || push) begin
        idle_p0 <= 16'd0;
      end else if (TMO_EN && vld_p0 && !i_valid) begin
        idle_p0 <= sat_inc(idle_p0, IDLE_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0 <= i_data;
    end
  end

  // Stage p1: registered output toward the downstream consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_last        <= 1'b0;
      o_burst_count <= 16'd0;
    end else begin
      if (push) begin
        o_valid <= 1'b1;
        o_data  <= data_p0;
        o_last  <= push_last;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (o_valid && i_ready && o_last) begin
        o_burst_count <= o_burst_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_burst_framer.sv
// Bench for burst_framer: four instances with different BURST_LEN/TIMEOUT, a
// vector table for streaming bursts and hand-written sequences for timing corners.
module tb_burst_framer;

  localparam int BL [4] = '{4, 4, 4, 1};
  localparam int TO [4] = '{16, 5, 0, 16};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  i_valid;
  logic [3:0]  i_flush;
  logic [3:0]  i_ready;
  logic [3:0]  o_ready;
  logic [3:0]  o_valid;
  logic [3:0]  o_last;
  logic [31:0] i_data [4];
  logic [31:0] o_data [4];
  logic [15:0] o_burst_count [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    burst_framer #(.BURST_LEN(BL[g]), .TIMEOUT(TO[g]), .DATA_W(32)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_valid       (i_valid[g]),
      .o_ready       (o_ready[g]),
      .i_data        (i_data[g]),
      .i_flush       (i_flush[g]),
      .o_valid       (o_valid[g]),
      .i_ready       (i_ready[g]),
      .o_data        (o_data[g]),
      .o_last        (o_last[g]),
      .o_burst_count (o_burst_count[g])
    );
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        last;
    int          gap;
  } vec_t;

  exp_t sb [$];
  vec_t tbl [$];
  int   total = 0;
  int   bad = 0;
  int   cur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int g, input logic [31:0] d, input logic last);
    int n = 0;
    i_valid[g] = 1'b1;
    i_data[g]  = d;
    sb.push_back('{d, last});
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready[g] && n < 200);
    if (!o_ready[g]) check("send_timeout", 32'(o_ready[g]), 32'd1);
    @(posedge clk);
    #1;
    i_valid[g] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [31:0] held;
    logic        stable;
    int          lat;
    exp_t        e;

    i_valid = '0;
    i_flush = '0;
    i_ready = '1;
    for (int g = 0; g < 4; g++) i_data[g] = '0;

    tbl.push_back('{0, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 32'h1, 1'b0, 0});
    tbl.push_back('{0, 32'h2, 1'b0, 0});
    tbl.push_back('{0, 32'h3, 1'b1, 0});
    tbl.push_back('{0, 32'h4, 1'b0, 0});
    tbl.push_back('{0, 32'h5, 1'b0, 0});
    tbl.push_back('{0, 32'h6, 1'b0, 0});
    tbl.push_back('{0, 32'h7, 1'b1, 0});
    tbl.push_back('{3, 32'h20, 1'b1, 0});
    tbl.push_back('{3, 32'h21, 1'b1, 2});
    tbl.push_back('{3, 32'h22, 1'b1, 0});

    #3;
    for (int g = 0; g < 4; g++) begin
      check("rst_o_valid", 32'(o_valid[g]), 32'd0);
      check("rst_o_ready", 32'(o_ready[g]), 32'd0);
      check("rst_o_data", o_data[g], 32'd0);
      check("rst_o_last", 32'(o_last[g]), 32'd0);
      check("rst_count", 32'(o_burst_count[g]), 32'd0);
    end

    fork
      forever begin
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
          if (o_valid[g] && i_ready[g]) begin
            check("stray_dut", 32'(g), 32'(cur));
            if (sb.size() == 0) begin
              check("unexpected_beat", o_data[g], 32'hFFFF_FFFF);
            end else begin
              e = sb.pop_front();
              check("out_data", o_data[g], e.data);
              check("out_last", 32'(o_last[g]), 32'(e.last));
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) check("ready_after_rst", 32'(o_ready[g]), 32'd1);

    // Streaming bursts from the vector table
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].dut != cur) begin
        drain();
        cur = tbl[i].dut;
      end
      send(tbl[i].dut, tbl[i].data, tbl[i].last);
      repeat (tbl[i].gap) @(posedge clk);
      if (tbl[i].gap != 0) #1;
    end
    drain();
    check("count_len4", 32'(o_burst_count[0]), 32'd2);
    check("count_len1", 32'(o_burst_count[3]), 32'd3);

    // Idle timeout closes a partial burst exactly TIMEOUT cycles after capture
    cur = 1;
    send(1, 32'hA, 1'b0);
    send(1, 32'hB, 1'b1);
    check("tmo_first_valid", 32'(o_valid[1]), 32'd1);
    check("tmo_first_data", o_data[1], 32'hA);
    check("tmo_first_last", 32'(o_last[1]), 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (o_valid[1] && o_data[1] == 32'hB) begin
        lat = k;
        break;
      end
    end
    check("tmo_latency", 32'(lat), 32'd5);
    check("tmo_last", 32'(o_last[1]), 32'd1);
    drain();
    check("tmo_count", 32'(o_burst_count[1]), 32'd1);

    // Flush with timeout disabled
    cur = 2;
    send(2, 32'h1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("no_close_without_flush", 32'(o_valid[2]), 32'd0);
    i_flush[2] = 1'b1;
    @(posedge clk);
    #1 i_flush[2] = 1'b0;
    check("flush_valid", 32'(o_valid[2]), 32'd1);
    check("flush_data", o_data[2], 32'h1);
    check("flush_last", 32'(o_last[2]), 32'd1);
    send(2, 32'h2, 1'b0);
    send(2, 32'h3, 1'b0);
    send(2, 32'h4, 1'b0);
    send(2, 32'h5, 1'b1);
    drain();
    check("flush_count", 32'(o_burst_count[2]), 32'd2);
    i_flush[2] = 1'b1;
    @(posedge clk);
    #1 i_flush[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("empty_flush_valid", 32'(o_valid[2]), 32'd0);
    check("empty_flush_count", 32'(o_burst_count[2]), 32'd2);

    // Downstream backpressure: both stages fill, output word holds steady
    cur = 0;
    i_ready[0] = 1'b0;
    send(0, 32'h10, 1'b0);
    send(0, 32'h11, 1'b0);
    check("bp_ready_low", 32'(o_ready[0]), 32'd0);
    check("bp_out_valid", 32'(o_valid[0]), 32'd1);
    check("bp_out_data", o_data[0], 32'h10);
    i_valid[0] = 1'b1;
    i_data[0]  = 32'h12;
    held   = o_data[0];
    stable = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (o_data[0] !== held || o_ready[0] !== 1'b0 || o_valid[0] !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    i_ready[0] = 1'b1;
    send(0, 32'h12, 1'b1);
    drain();
    check("bp_count", 32'(o_burst_count[0]), 32'd3);

    // Asynchronous reset mid-burst discards held and output words
    i_ready[0] = 1'b0;
    send(0, 32'h30, 1'b0);
    send(0, 32'h31, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(o_valid[0]), 32'd0);
    check("arst_count", 32'(o_burst_count[0]), 32'd0);
    check("arst_ready", 32'(o_ready[0]), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    i_ready[0] = 1'b1;
    send(0, 32'h40, 1'b0);
    send(0, 32'h41, 1'b0);
    send(0, 32'h42, 1'b0);
    send(0, 32'h43, 1'b1);
    drain();
    check("arst_new_count", 32'(o_burst_count[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
